uart_sample_framer: RTL and testbench
=====================================

// Module: uart_sample_framer
// PURPOSE
//   Turns ADC/FIR sample words into ASCII-hex text lines for the UART byte transmitter.
//   Sits directly upstream of the UART tx stage: it drives that stage's act/tx_data and obeys its busy.
//   Decimates the sample stream to fit the UART rate and counts selected samples it had to drop.
// PARAMETERS
//   DATA_W  12  sample width in bits; NIB = (DATA_W+3)/4 hex digits per line, top digit zero-padded
//   DECIM   1   send 1 of every DECIM sample_valid beats (DECIM>=1; 1 = every sample is selected)
//   DROP_W  16  width of the saturating drop counter
// PORTS
//   clk           in   1        system clock (single clock domain)
//   rst_n         in   1        asynchronous, active-low reset
//   sample_valid  in   1        1-cycle strobe: sample_data is valid
//   sample_data   in   DATA_W   sample word, unsigned, interpreted as raw bits
//   sample_ready  out  1        1 when state==IDLE (informational; upstream never stalls)
//   tx_act        out  1        1-cycle start pulse to the UART tx stage (registered)
//   tx_data       out  8        byte to send; stable from the tx_act cycle until the next PULSE
//   tx_busy       in   1        busy from the UART tx stage; rises 1 cycle after act, falls at end of stop bit
//   frame_busy    out  1        1 from acceptance until return to IDLE
//   drop_cnt      out  DROP_W   number of selected samples lost because a frame was in progress
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, tx_act=0, tx_data=8'h00, frame_busy=0, drop_cnt=0,
//     decim_cnt=0, char_idx=0. A reset mid-frame aborts the frame at once; no further bytes are issued.
//   Decimation: decim_cnt counts sample_valid beats 0..DECIM-1 and wraps, in every state.
//     A beat is "selected" when sample_valid=1 and decim_cnt==0.
//   Accept: selected beat while IDLE -> latch sample_data, char_idx=0, go to PULSE.
//   Drop: selected beat while not IDLE -> drop_cnt+1, saturating at all-ones; the sample is discarded.
//     Unselected beats are silently ignored (not counted).
//   Line format, LEN = NIB+2 bytes: hex digits MSB nibble first, then 8'h0D, 8'h0A.
//     Digits: 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46 (uppercase).
//   FSM (state and all outputs registered):
//     IDLE    : tx_act=0. On accept -> PULSE.
//     PULSE   : tx_act=1 for exactly this cycle, tx_data=char[char_idx] -> WAIT_HI.
//     WAIT_HI : wait for tx_busy=1 -> WAIT_LO. No timeout; the tx stage always answers act.
//     WAIT_LO : wait for tx_busy=0; then if char_idx==LEN-1 -> IDLE, else char_idx+1 -> PULSE.
//   Latency: tx_act is high in the cycle after the accepting edge. Each following PULSE comes
//     1 cycle after tx_busy is seen low, so the tx stage is back in IDLE when act arrives.
//   tx_act is never high while tx_busy=1; tx_act is never high for 2 consecutive cycles.
//   frame_busy = (state != IDLE). sample_ready = (state == IDLE).
//   Acceptance and drop are mutually exclusive in any cycle; a selected beat in the cycle the FSM
//     returns to IDLE (state still WAIT_LO) is a drop.
//   The latched sample does not change during a frame; sample_data is ignored outside acceptance.
// TESTING (bench contains a UART tx model with div_ratio=4 and a serial decoder)
//   sample_data=12'hA5C, one valid -> bytes 41,35,43,0D,0A in order; tx_act 5 pulses; frame_busy ends 0.
//   12'h000 then, after frame_busy falls, 12'hFFF -> "000\r\n" then "FFF\r\n"; drop_cnt=0.
//   DECIM=4, valid every cycle for 8 beats from reset -> only beats 0 and 4 are selected;
//     beat 0 is sent, beat 4 arrives mid-frame -> drop_cnt=1; beats 1-3 and 5-7 are not counted.
//   DROP_W=3, 12 selected beats during one frame -> drop_cnt stops at 7 and holds.
//   rst_n pulled low during the 3rd byte -> outputs at reset values within 0 clocks; no tx_act after release
//     until a new selected sample arrives.
//   Check every cycle: tx_act&&tx_busy never; tx_act high at most 1 consecutive cycle; tx_data stable while tx_busy=1.

Source files
------------

// File: rtl/uart_sample_framer.sv
// uart_sample_framer: decimates a sample stream and emits each selected sample
// as an uppercase ASCII-hex line ("XYZ\r\n") through a byte-wide UART tx stage,
// using the tx stage's act/busy handshake. Selected samples that arrive while a
// line is still being sent are discarded and counted in a saturating counter.
module uart_sample_framer #(
    parameter int DATA_W = 12,
    parameter int DECIM  = 1,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic              tx_act,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              frame_busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int NIB   = (DATA_W + 3) / 4;
    localparam int LEN   = NIB + 2;
    localparam int PAD_W = NIB * 4;
    localparam int IDX_W = $clog2(LEN);
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  char_idx, char_idx_next;
    logic              tx_act_next;
    logic [7:0]        tx_data_next;
    logic [DEC_W-1:0]  decim_cnt;
    logic [PAD_W-1:0]  sample_pad;
    logic [PAD_W-1:0]  sample_q;
    logic              selected;
    logic              accept;
    logic              drop;

    // One hex digit to its uppercase ASCII code.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte idx of the text line for sample s: digits MSB first, then CR, LF.
    function automatic logic [7:0] line_byte(input logic [PAD_W-1:0] s,
                                             input logic [IDX_W-1:0] idx);
        logic [PAD_W-1:0] shifted;
        int               sh;
        if (idx == IDX_W'(NIB))     return 8'h0D;
        if (idx == IDX_W'(NIB + 1)) return 8'h0A;
        sh      = (NIB - 1 - int'(idx)) * 4;
        shifted = s >> sh;
        return hex_ascii(shifted[3:0]);
    endfunction

    // Top digit is zero-padded when DATA_W is not a multiple of 4.
    assign sample_pad = PAD_W'(sample_data);

    assign selected     = sample_valid && (decim_cnt == '0);
    assign accept       = selected && (state == IDLE);
    assign drop         = selected && (state != IDLE);
    assign frame_busy   = (state != IDLE);
    assign sample_ready = (state == IDLE);

    // Decimation phase: counts every valid beat, regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            decim_cnt <= '0;
        end else if (sample_valid) begin
            if (decim_cnt == DEC_W'(DECIM - 1)) decim_cnt <= '0;
            else                                decim_cnt <= decim_cnt + DEC_W'(1);
        end
    end

    // Saturating count of selected samples lost to an in-progress frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    // Latched sample for the frame being sent.
    always_ff @(posedge clk) begin
        // NOTE: pure data register, no reset: it is only read after an accept has loaded it.
        if (accept) sample_q <= sample_pad;
    end

    // State, character index and registered tx outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            char_idx <= '0;
            tx_act   <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_next;
            char_idx <= char_idx_next;
            tx_act   <= tx_act_next;
            tx_data  <= tx_data_next;
        end
    end

    // Next-state logic; tx_act/tx_data are precomputed for the PULSE cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next    = state;
        char_idx_next = char_idx;
        tx_act_next   = 1'b0;
        tx_data_next  = tx_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = PULSE;
                    char_idx_next = '0;
                    tx_act_next   = 1'b1;
                    tx_data_next  = line_byte(sample_pad, '0);
                end
            end
            PULSE: begin
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (char_idx == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        state_next    = PULSE;
                        char_idx_next = char_idx + IDX_W'(1);
                        tx_act_next   = 1'b1;
                        tx_data_next  = line_byte(sample_q, char_idx + IDX_W'(1));
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_sample_framer.sv
// Testbench for uart_sample_framer: three instances (default, DECIM=4,
// DROP_W=3), each driving a UART tx model (4 clocks per bit) whose serial line
// is decoded back into bytes. A transaction-level model predicts frame_busy,
// tx_act/tx_data, drop_cnt and the decoded text for every cycle.
module tb_uart_sample_framer;

    localparam int LEN = 5;
    localparam int DEC  [3] = '{1, 4, 1};
    localparam int DMAX [3] = '{65535, 65535, 7};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sv [3];
    logic [11:0] sd [3];
    logic        sr [3];
    logic        ta [3];
    logic [7:0]  td [3];
    logic        fb [3];
    logic [15:0] dc0, dc1;
    logic [2:0]  dc2;
    logic [15:0] drop_ext [3];

    // UART tx model state
    logic        tx_busy  [3];
    int          tx_cnt   [3];
    logic [9:0]  tx_frame [3];
    logic [7:0]  tx_byte  [3];

    // serial decoder state
    logic        dec_on  [3];
    int          dec_cnt [3];
    logic [7:0]  dec_sh  [3];
    logic [7:0]  dec_q   [3][$];

    // reference model state
    int          m_beat [3];
    int          m_drop [3];
    int          m_done [3];
    bit          m_in   [3];
    bit          m_act  [3];
    bit          m_prev_busy [3];
    logic [7:0]  m_char [3];
    logic [11:0] m_sample [3];
    logic [7:0]  exp_q  [3][$];

    // compare process state
    int          dec_rd  [3];
    int          act_cnt [3];
    logic        prev_act [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_sample_framer #(.DATA_W(12), .DECIM(1), .DROP_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv[0]), .sample_data(sd[0]),
        .sample_ready(sr[0]), .tx_act(ta[0]), .tx_data(td[0]), .tx_busy(tx_busy[0]),
        .frame_busy(fb[0]), .drop_cnt(dc0));

    uart_sample_framer #(.DATA_W(12), .DECIM(4), .DROP_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv[1]), .sample_data(sd[1]),
        .sample_ready(sr[1]), .tx_act(ta[1]), .tx_data(td[1]), .tx_busy(tx_busy[1]),
        .frame_busy(fb[1]), .drop_cnt(dc1));

    uart_sample_framer #(.DATA_W(12), .DECIM(1), .DROP_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv[2]), .sample_data(sd[2]),
        .sample_ready(sr[2]), .tx_act(ta[2]), .tx_data(td[2]), .tx_busy(tx_busy[2]),
        .frame_busy(fb[2]), .drop_cnt(dc2));

    assign drop_ext[0] = dc0;
    assign drop_ext[1] = dc1;
    assign drop_ext[2] = {13'd0, dc2};

    task automatic check(input string name, input int ch, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s ch%0d @%0t: got %0h, expected %0h", name, ch, $time, act, exp);
        end
    endtask

    // Text of a sample line: three uppercase hex digits, CR, LF.
    function automatic logic [7:0] line_char(input logic [11:0] s, input int idx);
        string hex = "0123456789ABCDEF";
        if (idx == 3) return 8'h0D;
        if (idx == 4) return 8'h0A;
        return 8'(hex[int'((s >> (4 * (2 - idx))) & 12'hF)]);
    endfunction

    // UART tx model: busy rises the cycle after act, lasts 10 bits of 4 clocks.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                tx_busy[c]  <= 1'b0;
                tx_cnt[c]   <= 0;
                tx_frame[c] <= 10'h3FF;
                tx_byte[c]  <= 8'h00;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (!tx_busy[c]) begin
                    if (ta[c]) begin
                        tx_busy[c]  <= 1'b1;
                        tx_cnt[c]   <= 0;
                        tx_frame[c] <= {1'b1, td[c], 1'b0};
                        tx_byte[c]  <= td[c];
                    end
                end else if (tx_cnt[c] == 39) begin
                    tx_busy[c] <= 1'b0;
                end else begin
                    tx_cnt[c] <= tx_cnt[c] + 1;
                end
            end
        end
    end

    // Serial decoder: samples each bit mid-cell and collects received bytes.
    always @(posedge clk or negedge rst_n) begin
        logic ln;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                dec_on[c]  <= 1'b0;
                dec_cnt[c] <= 0;
                dec_sh[c]  <= 8'h00;
                dec_q[c].delete();
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                ln = tx_busy[c] ? tx_frame[c][tx_cnt[c] / 4] : 1'b1;
                if (!dec_on[c]) begin
                    if (!ln) begin
                        dec_on[c]  <= 1'b1;
                        dec_cnt[c] <= 1;
                    end
                end else begin
                    if ((dec_cnt[c] % 4 == 2) && dec_cnt[c] >= 6 && dec_cnt[c] <= 34)
                        dec_sh[c][(dec_cnt[c] - 6) / 4] <= ln;
                    if (dec_cnt[c] == 38) dec_q[c].push_back(dec_sh[c]);
                    if (dec_cnt[c] == 39) dec_on[c] <= 1'b0;
                    else                  dec_cnt[c] <= dec_cnt[c] + 1;
                end
            end
        end
    end

    // Reference model: a frame is LEN bytes, each closed by a busy falling edge.
    always @(posedge clk or negedge rst_n) begin
        bit sel, fall, in_f, act;
        int done;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                m_beat[c] <= 0;
                m_drop[c] <= 0;
                m_done[c] <= 0;
                m_in[c]   <= 1'b0;
                m_act[c]  <= 1'b0;
                m_prev_busy[c] <= 1'b0;
                m_char[c] <= 8'h00;
                exp_q[c].delete();
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                sel  = sv[c] && (m_beat[c] == 0);
                fall = m_prev_busy[c] && !tx_busy[c];
                in_f = m_in[c];
                done = m_done[c];
                act  = 1'b0;
                if (sv[c]) m_beat[c] <= (m_beat[c] + 1) % DEC[c];
                m_prev_busy[c] <= tx_busy[c];
                if (in_f && fall) begin
                    done = done + 1;
                    if (done == LEN) begin
                        in_f = 1'b0;
                    end else begin
                        act = 1'b1;
                        m_char[c] <= line_char(m_sample[c], done);
                    end
                end
                if (sel) begin
                    if (m_in[c]) begin
                        if (m_drop[c] < DMAX[c]) m_drop[c] <= m_drop[c] + 1;
                    end else begin
                        in_f = 1'b1;
                        done = 0;
                        act  = 1'b1;
                        m_sample[c] <= sd[c];
                        m_char[c]   <= line_char(sd[c], 0);
                        for (int k = 0; k < LEN; k++) exp_q[c].push_back(line_char(sd[c], k));
                    end
                end
                m_in[c]   <= in_f;
                m_done[c] <= done;
                m_act[c]  <= act;
            end
        end
    end

    // Per-cycle comparison of every DUT against the model and the handshake rules.
    always @(negedge clk) begin
        int e;
        for (int c = 0; c < 3; c++) begin
            check("frame_busy", c, int'(fb[c]), int'(m_in[c]));
            check("sample_ready", c, int'(sr[c]), int'(!m_in[c]));
            check("tx_act", c, int'(ta[c]), int'(m_act[c]));
            if (m_act[c]) check("tx_data", c, int'(td[c]), int'(m_char[c]));
            check("drop_cnt", c, int'(drop_ext[c]), m_drop[c]);
            check("act_while_busy", c, int'(ta[c] && tx_busy[c]), 0);
            check("act_two_cycles", c, int'(ta[c] && prev_act[c]), 0);
            if (tx_busy[c]) check("tx_data_stable", c, int'(td[c]), int'(tx_byte[c]));
            if (!rst_n) begin
                dec_rd[c]   <= 0;
                prev_act[c] <= 1'b0;
            end else begin
                prev_act[c] <= ta[c];
                if (dec_rd[c] < dec_q[c].size()) begin
                    e = (dec_rd[c] < exp_q[c].size()) ? int'(exp_q[c][dec_rd[c]]) : -1;
                    check("serial_byte", c, int'(dec_q[c][dec_rd[c]]), e);
                    dec_rd[c] <= dec_rd[c] + 1;
                end
            end
            act_cnt[c] <= act_cnt[c] + int'(ta[c]);
        end
    end

    task automatic clear_inputs();
        for (int c = 0; c < 3; c++) sv[c] = 1'b0;
    endtask

    task automatic send(input int c, input logic [11:0] data);
        @(negedge clk);
        sv[c] = 1'b1;
        sd[c] = data;
        @(negedge clk);
        sv[c] = 1'b0;
    endtask

    task automatic wait_all_idle(input int max_cycles);
        int n = 0;
        @(negedge clk);
        while ((fb[0] || fb[1] || fb[2] || tx_busy[0] || tx_busy[1] || tx_busy[2])
               && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 0, int'(n < max_cycles), 1);
    endtask

    // Compares five received bytes starting at base against a packed literal line.
    task automatic check_line(input string name, input int c, input int base,
                              input logic [39:0] line);
        logic [7:0] got;
        for (int k = 0; k < LEN; k++) begin
            got = (base + k < dec_q[c].size()) ? dec_q[c][base + k] : 8'hFF;
            check(name, c, int'(got), int'(line[39 - 8 * k -: 8]));
        end
    endtask

    initial begin
        int base0, base1, base2, acts;
        for (int c = 0; c < 3; c++) begin
            sv[c] = 1'b0;
            sd[c] = 12'h000;
            act_cnt[c] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_frame_busy", 0, int'(fb[0]), 0);
        check("reset_tx_data", 0, int'(td[0]), 0);

        // ch0: one sample; ch1: 8 back-to-back beats with DECIM=4; ch2: 13 beats.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            sv[0] = (i == 0);
            sd[0] = 12'hA5C;
            sv[1] = (i < 8);
            sd[1] = (i == 0) ? 12'h123 : 12'($urandom);
            sv[2] = 1'b1;
            sd[2] = (i == 0) ? 12'h7E1 : 12'($urandom);
        end
        @(negedge clk);
        clear_inputs();
        wait_all_idle(3000);
        check_line("line_a5c", 0, 0, {8'h41, 8'h35, 8'h43, 8'h0D, 8'h0A});
        check("act_pulses_a5c", 0, act_cnt[0], 5);
        check("frame_busy_end", 0, int'(fb[0]), 0);
        check_line("line_decim", 1, 0, {8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A});
        check("drop_decim", 1, int'(drop_ext[1]), 1);
        check_line("line_sat", 2, 0, {8'h37, 8'h45, 8'h31, 8'h0D, 8'h0A});
        check("drop_saturated", 2, int'(drop_ext[2]), 7);

        // ch0: all-zero then all-ones sample, sent back to back.
        base0 = dec_q[0].size();
        send(0, 12'h000);
        wait_all_idle(2000);
        send(0, 12'hFFF);
        wait_all_idle(2000);
        check_line("line_000", 0, base0, {8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A});
        check_line("line_fff", 0, base0 + 5, {8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A});
        check("drop_none", 0, int'(drop_ext[0]), 0);

        // Random sparse traffic on all channels, checked cycle by cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                sv[c] = ($urandom_range(0, 59) == 0);
                sd[c] = 12'($urandom);
            end
        end
        @(negedge clk);
        clear_inputs();
        wait_all_idle(3000);
        check("random_had_drops", 0, int'(drop_ext[0] != 0 || drop_ext[1] != 0), 1);

        // Reset during the third byte of a frame.
        acts = act_cnt[0];
        send(0, 12'h3B7);
        base1 = 0;
        while (act_cnt[0] < acts + 3 && base1 < 1000) begin
            @(negedge clk);
            base1++;
        end
        check("third_byte_timeout", 0, int'(base1 < 1000), 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_tx_act", 0, int'(ta[0]), 0);
        check("async_rst_tx_data", 0, int'(td[0]), 0);
        check("async_rst_frame_busy", 0, int'(fb[0]), 0);
        check("async_rst_ready", 0, int'(sr[0]), 1);
        check("async_rst_drop", 0, int'(drop_ext[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base2 = act_cnt[0];
        repeat (300) @(negedge clk);
        check("no_act_after_reset", 0, act_cnt[0], base2);
        send(0, 12'h1E0);
        wait_all_idle(2000);
        check_line("line_after_reset", 0, 0, {8'h31, 8'h45, 8'h30, 8'h0D, 8'h0A});
        check("act_pulses_after_reset", 0, act_cnt[0], base2 + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
